// File: rtl/freq_counter_gated.sv
// ---------------------------------------------------------------------------
// freq_counter_gated
//
// Gated BCD frequency counter. An asynchronous input is synchronised, its
// rising edges are counted in BCD over a programmable gate window, and at
// the end of every completed gate the count is latched together with an
// overflow flag, the decimal-point position and a one-cycle valid strobe.
// Gates run back to back while enable_in is high, with no dead cycle.
//
// Ports
//   clk_in     : system clock
//   resetn_in  : asynchronous active-low reset
//   enable_in  : 1 = run back-to-back gates, 0 = idle (aborts a running gate)
//   range_in   : gate select, 0 = GATE_CYCLES, 1 = /10, 2 and 3 = /100
//   signal_in  : asynchronous signal whose rising edges are counted
//   digits     : latched BCD result, digit 0 in bits [3:0]
//   overflow   : latched, last gate exceeded the BCD capacity
//   dp_pos     : latched range of the last result (0, 1 or 2)
//   valid      : one-cycle pulse when a new result is latched
// ---------------------------------------------------------------------------
module freq_counter_gated #(
  parameter int DIGITS_NUM  = 6,
  parameter int GATE_CYCLES = 1000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk_in,
  input  logic                    resetn_in,
  input  logic                    enable_in,
  input  logic [1:0]              range_in,
  input  logic                    signal_in,
  output logic [4*DIGITS_NUM-1:0] digits,
  output logic                    overflow,
  output logic [1:0]              dp_pos,
  output logic                    valid
);

  localparam int GW = $clog2(GATE_CYCLES + 1);
  localparam int CW = 4 * DIGITS_NUM;

  localparam logic [GW-1:0] LEN_R0 = GW'(GATE_CYCLES);
  localparam logic [GW-1:0] LEN_R1 = GW'(GATE_CYCLES / 10);
  localparam logic [GW-1:0] LEN_R2 = GW'(GATE_CYCLES / 100);

  typedef enum logic {
    IDLE = 1'b0,
    GATE = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] syncFf_q;
  logic                   prev_q;
  logic [GW-1:0]          gateCnt_q, gateCnt_d;
  logic [1:0]             range_q, range_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   ovf_q, ovf_d;
  logic [CW-1:0]          digits_q, digits_d;
  logic                   overflow_q, overflow_d;
  logic [1:0]             dpPos_q, dpPos_d;
  logic                   valid_q, valid_d;

  logic                   syncOut;
  logic                   risingEdge;
  logic [1:0]             rangeSel;
  logic [GW-1:0]          lenSel;
  logic [CW:0]            incResult;
  logic [CW-1:0]          countStep;
  logic                   ovfStep;

  // BCD increment across all digits. The top bit of the result is the carry
  // out of the most significant digit, i.e. the increment started from all-9s.
  function automatic logic [CW:0] bcdIncrement(input logic [CW-1:0] value);
    logic [CW-1:0] result;
    logic          carry;
    result = value;
    carry  = 1'b1;
    for (int i = 0; i < DIGITS_NUM; i++) begin
      if (carry) begin
        if (value[4*i +: 4] >= 4'd9) begin
          result[4*i +: 4] = 4'd0;
        end else begin
          result[4*i +: 4] = value[4*i +: 4] + 4'd1;
          carry            = 1'b0;
        end
      end
    end
    return {carry, result};
  endfunction

  assign syncOut    = syncFf_q[SYNC_STAGES-1];
  assign risingEdge = syncOut & ~prev_q;

  // Range 3 behaves exactly like range 2, so it is folded at the sample point
  // and dp_pos only ever reports 0, 1 or 2.
  assign rangeSel = (range_in == 2'd3) ? 2'd2 : range_in;

  always_comb begin
    case (rangeSel)
      2'd0:    lenSel = LEN_R0;
      2'd1:    lenSel = LEN_R1;
      default: lenSel = LEN_R2;
    endcase
  end

  // Count value after taking this cycle's edge into account. An increment
  // out of all-9s sets the overflow flag and leaves the count saturated.
  always_comb begin
    incResult = bcdIncrement(count_q);
    countStep = count_q;
    ovfStep   = ovf_q;
    if (risingEdge) begin
      if (incResult[CW]) begin
        ovfStep = 1'b1;
      end else begin
        countStep = incResult[CW-1:0];
      end
    end
  end

  // Synchroniser chain plus the previous-value register for edge detection.
  // prev_q follows the synchroniser in every state so that a level already
  // high when a gate opens never looks like a fresh edge.
  always_ff @(posedge clk_in or negedge resetn_in) begin
    if (!resetn_in) begin
      syncFf_q <= '0;
      prev_q   <= 1'b0;
    end else begin
      syncFf_q <= {syncFf_q[SYNC_STAGES-2:0], signal_in};
      prev_q   <= syncOut;
    end
  end

  // Next-state logic. The terminal cycle (gate counter at 1) closes the
  // result even if enable_in has dropped in that same cycle, and reloads the
  // gate counter straight away when enable_in is high so consecutive gates
  // have no gap between them.
  always_comb begin
    state_d    = state_q;
    gateCnt_d  = gateCnt_q;
    range_d    = range_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    digits_d   = digits_q;
    overflow_d = overflow_q;
    dpPos_d    = dpPos_q;
    valid_d    = 1'b0;

    case (state_q)
      IDLE: begin
        count_d = '0;
        ovf_d   = 1'b0;
        if (enable_in) begin
          state_d   = GATE;
          range_d   = rangeSel;
          gateCnt_d = lenSel;
        end
      end

      GATE: begin
        if (gateCnt_q == GW'(1)) begin
          digits_d   = countStep;
          overflow_d = ovfStep;
          dpPos_d    = range_q;
          valid_d    = 1'b1;
          count_d    = '0;
          ovf_d      = 1'b0;
          if (enable_in) begin
            range_d   = rangeSel;
            gateCnt_d = lenSel;
          end else begin
            state_d = IDLE;
          end
        end else if (!enable_in) begin
          state_d = IDLE;
          count_d = '0;
          ovf_d   = 1'b0;
        end else begin
          count_d   = countStep;
          ovf_d     = ovfStep;
          gateCnt_d = gateCnt_q - GW'(1);
        end
      end

      default: begin
        state_d = IDLE;
        count_d = '0;
        ovf_d   = 1'b0;
      end
    endcase
  end

  // Control state, running count and latched result registers.
  always_ff @(posedge clk_in or negedge resetn_in) begin
    if (!resetn_in) begin
      state_q    <= IDLE;
      gateCnt_q  <= '0;
      range_q    <= 2'd0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      digits_q   <= '0;
      overflow_q <= 1'b0;
      dpPos_q    <= 2'd0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      gateCnt_q  <= gateCnt_d;
      range_q    <= range_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      digits_q   <= digits_d;
      overflow_q <= overflow_d;
      dpPos_q    <= dpPos_d;
      valid_q    <= valid_d;
    end
  end

  assign digits   = digits_q;
  assign overflow = overflow_q;
  assign dp_pos   = dpPos_q;
  assign valid    = valid_q;

endmodule

// File: doc/freq_counter_gated.md
Name: freq_counter_gated

Overview:
- Parametrised gated frequency counter, the successor to the fixed 6-digit free-running BCD counter.
- Synchronises an asynchronous input and counts its rising edges in BCD over a programmable gate window.
- Adds decade gate-range selection, overflow saturation and a latched result with a valid strobe.
- Feeds the OLED display path: the digits and the decimal-point position go to the SSD1306 text renderer.

Parameters:
- DIGITS_NUM, 6: number of BCD digits in the count and result.
- GATE_CYCLES, 1000000: clk_in cycles in the range-0 gate window. Must be a multiple of 100 and at least 100.
- SYNC_STAGES, 2: flip-flops in the signal_in synchroniser. Minimum 2.

Ports:
- clk_in  in  1  system clock.
- resetn_in  in  1  asynchronous active-low reset.
- enable_in  in  1  high = run back-to-back gates; low = idle.
- range_in  in  2  gate select. 0: GATE_CYCLES; 1: GATE_CYCLES/10; 2 and 3: GATE_CYCLES/100.
- signal_in  in  1  asynchronous signal to measure.
- digits  out  4*DIGITS_NUM  latched BCD result; digit 0 in bits [3:0].
- overflow  out  1  latched: last gate exceeded the BCD capacity.
- dp_pos  out  2  latched range of the last result (0, 1 or 2).
- valid  out  1  one-cycle pulse when a new result is latched.

Behaviour:
- Reset, asynchronous and active-low:
  - digits=0, overflow=0, dp_pos=0, valid=0.
  - FSM goes to IDLE; gate counter, running count and synchroniser flops clear to 0.
- Synchroniser: SYNC_STAGES flops, then a prev register. Edge = sync_out & ~prev.
  - Edge latency from a signal_in transition: SYNC_STAGES+1 cycles.
  - The maximum countable rate is one edge per 2 clk_in cycles.
- FSM states: IDLE, GATE.
  - IDLE:
    - The running count is held at 0.
    - prev tracks sync_out every cycle, so a level held high on entry to GATE is not counted.
    - When enable_in=1: sample range_in into a range register, load the gate counter with the selected length L, and go to GATE.
  - GATE: lasts exactly L cycles.
    - Each edge increments the running count by one in BCD, in a single cycle.
    - BCD increment: digit 9 wraps to 0 and carries to the next digit.
    - On the terminal cycle (gate counter = 1), an edge in that cycle is included in the closing result.
- Saturation:
  - An increment from all-9s sets an internal ovf flag.
  - The count stays all-9s until the gate ends. No wrap.
- Terminal cycle, registered outputs updated on the next edge:
  - digits <= count including any terminal edge (all-9s if ovf).
  - overflow <= ovf.
  - dp_pos <= range register.
  - valid <= 1 for one cycle.
  - The running count and ovf clear.
- After the terminal cycle:
  - If enable_in=1: re-sample range_in and start the next gate immediately, with no dead cycle. An edge in the first cycle of the new gate counts into the new gate.
  - Otherwise go to IDLE.
- Abort: enable_in=0 mid-gate → IDLE next cycle.
  - The running count is discarded; no valid pulse.
  - digits, overflow and dp_pos hold their previous values.
- Range changes mid-gate are ignored until the next gate start.
- The gate counter is $clog2(GATE_CYCLES+1) bits wide. L for range 3 equals L for range 2.
- Between gates, outputs are stable; valid is low except for the one pulse per completed gate.
- Reset asserted mid-gate: immediate return to reset values; no valid pulse.

Test Plan:
- Bench parameters for all scenarios: DIGITS_NUM=3, GATE_CYCLES=4000, SYNC_STAGES=2.
- Range 0, signal_in period 8 clk, enable held high → valid pulses every 4000 cycles; digits=12'h500, overflow=0, dp_pos=0. Successive results are identical, proving no dead time.
- Range 1, same signal → valid every 400 cycles; digits=12'h050, dp_pos=1. Range 2 → valid every 40 cycles; digits=12'h005, dp_pos=2. Range 3 → same as range 2.
- Range 0, signal_in period 2 clk (2000 edges) → digits=12'h999, overflow=1. A following gate at period 8 → digits=12'h500, overflow=0.
- Drop enable_in at cycle 2000 of a gate → no valid pulse; digits keep the prior 12'h500. Re-enable → a full 4000-cycle gate yields 12'h500 again.
- Constant-high signal_in during IDLE, then enable → digits=12'h000. An edge aligned with the terminal cycle counts in the closing gate, verified by the 499 → 500 boundary.
- Assert resetn_in low mid-gate → all outputs 0 asynchronously, before the next clk_in edge.
- Change range_in from 0 to 1 mid-gate → the current result still uses a 4000-cycle gate; the next gate uses 400.
